// File: rtl/register_file.sv
// register_file: 2**ADDR_W x DATA_W register file, two bypassable read ports, one write port, debug port
module register_file #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter bit BYPASS = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] Read_reg1,
    input  logic [ADDR_W-1:0] Read_reg2,
    output logic [DATA_W-1:0] Src1,
    output logic [DATA_W-1:0] Src2,
    input  logic              Reg_write,
    input  logic [ADDR_W-1:0] Write_reg,
    input  logic [DATA_W-1:0] Write_data,
    input  logic [ADDR_W-1:0] Dbg_reg,
    output logic [DATA_W-1:0] Dbg_data
);
    localparam int N = 2 ** ADDR_W;
    logic [DATA_W-1:0] regs [N];
    logic              wr_ok;
    assign wr_ok = Reg_write && (Write_reg != '0);
    // Async clear; entry 0 is never written so it stays zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) regs[i] <= '0;
        end else if (wr_ok) begin
            regs[Write_reg] <= Write_data;
        end
    end
    // Read ports: index 0 forced to zero, forwarding gated off while in reset
    always_comb begin
        Src1     = (Read_reg1 == '0) ? '0 :
                   (BYPASS && rst_n && wr_ok && Write_reg == Read_reg1) ? Write_data : regs[Read_reg1];
        Src2     = (Read_reg2 == '0) ? '0 :
                   (BYPASS && rst_n && wr_ok && Write_reg == Read_reg2) ? Write_data : regs[Read_reg2];
        Dbg_data = (Dbg_reg == '0) ? '0 : regs[Dbg_reg];
    end
endmodule

// File: tb/tb_register_file.sv
// tb_register_file: directed, table-driven and randomized checks of register_file (bypass and no-bypass)
module tb_register_file;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [4:0]  r1 = '0, r2 = '0, wr = '0, dbg = '0;
    logic        we = 1'b0;
    logic [31:0] wd = '0;
    logic [31:0] s1, s2, dd, n1, n2, nd;
    logic [31:0] mem [32];
    int          nchk = 0, nerr = 0;

    register_file #(.DATA_W(32), .ADDR_W(5), .BYPASS(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .Read_reg1(r1), .Read_reg2(r2), .Src1(s1), .Src2(s2),
        .Reg_write(we), .Write_reg(wr), .Write_data(wd), .Dbg_reg(dbg), .Dbg_data(dd));
    register_file #(.DATA_W(32), .ADDR_W(5), .BYPASS(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n), .Read_reg1(r1), .Read_reg2(r2), .Src1(n1), .Src2(n2),
        .Reg_write(we), .Write_reg(wr), .Write_data(wd), .Dbg_reg(dbg), .Dbg_data(nd));

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [4:0]  wr;
        logic [31:0] wd;
        logic [4:0]  r1, r2, dbg;
        logic [31:0] e1, e2, ed, en;
    } vec_t;
    vec_t tbl [7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference read: zero index, optional forwarding of a live write, else stored value
    function automatic logic [31:0] ref_rd(input logic [4:0] idx, input bit byp);
        if (idx == 0) return 32'h0;
        if (byp && rst_n && we && wr != 0 && wr == idx) return wd;
        return mem[idx];
    endfunction

    task automatic commit();
        @(posedge clk);
        if (rst_n && we && wr != 0) mem[wr] = wd;
    endtask

    task automatic do_write(input logic [4:0] a, input logic [31:0] d);
        @(negedge clk);
        we = 1'b1; wr = a; wd = d;
        commit();
        @(negedge clk);
        we = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = '0;
        tbl[0] = '{1'b1, 5'd5,  32'h1111_1111, 5'd5, 5'd5,  5'd5,  32'h1111_1111, 32'h1111_1111, 32'hA5A5_0006, 32'hA5A5_0006};
        tbl[1] = '{1'b1, 5'd5,  32'h2222_2222, 5'd5, 5'd5,  5'd5,  32'h2222_2222, 32'h2222_2222, 32'h1111_1111, 32'h1111_1111};
        tbl[2] = '{1'b0, 5'd5,  32'h3333_3333, 5'd5, 5'd5,  5'd5,  32'h2222_2222, 32'h2222_2222, 32'h2222_2222, 32'h2222_2222};
        tbl[3] = '{1'b1, 5'd0,  32'hFFFF_FFFF, 5'd0, 5'd5,  5'd0,  32'h0,         32'h2222_2222, 32'h0,         32'h0};
        tbl[4] = '{1'b1, 5'd9,  32'hCAFE_F00D, 5'd9, 5'd10, 5'd9,  32'hCAFE_F00D, 32'hA5A5_000B, 32'hA5A5_000A, 32'hA5A5_000A};
        tbl[5] = '{1'b0, 5'd9,  32'h0,         5'd9, 5'd9,  5'd9,  32'hCAFE_F00D, 32'hCAFE_F00D, 32'hCAFE_F00D, 32'hCAFE_F00D};
        tbl[6] = '{1'b1, 5'd31, 32'h0,         5'd30, 5'd31, 5'd31, 32'hA5A5_001F, 32'h0,        32'hA5A5_0020, 32'hA5A5_001F};

        // Ports read zero while in reset, even with a write driven
        we = 1'b1; wr = 5'd3; wd = 32'h5555_5555; r1 = 5'd3; r2 = 5'd3; dbg = 5'd3;
        @(negedge clk);
        chk("rst_src1", s1, 32'h0);
        chk("rst_dbg", dd, 32'h0);
        @(negedge clk);
        we = 1'b0;
        rst_n = 1'b1;

        // 1: sweep after reset
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            r1 = 5'(i); r2 = 5'(i); dbg = 5'(i);
            #1;
            chk("sweep_src1", s1, 32'h0);
            chk("sweep_src2", s2, 32'h0);
            chk("sweep_dbg", dd, 32'h0);
        end

        // 2: fill and read back
        for (int i = 1; i < 32; i++) do_write(5'(i), 32'hA5A5_0001 + 32'(i));
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            r1 = 5'(i); r2 = 5'(31 - i); dbg = 5'(i);
            #1;
            chk("fill_src1", s1, i == 0 ? 32'h0 : 32'hA5A5_0001 + 32'(i));
            chk("fill_src2", s2, i == 31 ? 32'h0 : 32'hA5A5_0001 + 32'(31 - i));
            chk("fill_dbg", dd, i == 0 ? 32'h0 : 32'hA5A5_0001 + 32'(i));
        end

        // 3: write to index 0 is discarded, pending or committed
        @(negedge clk);
        we = 1'b1; wr = 5'd0; wd = 32'hFFFF_FFFF; r1 = 5'd0; r2 = 5'd0; dbg = 5'd0;
        #1;
        chk("zero_pending_src1", s1, 32'h0);
        commit();
        @(negedge clk);
        we = 1'b0;
        #1;
        chk("zero_src1", s1, 32'h0);
        chk("zero_src2", s2, 32'h0);
        chk("zero_dbg", dd, 32'h0);

        // 4: table of bypass/no-bypass vectors, one cycle each
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            we = tbl[k].we; wr = tbl[k].wr; wd = tbl[k].wd;
            r1 = tbl[k].r1; r2 = tbl[k].r2; dbg = tbl[k].dbg;
            #1;
            chk($sformatf("tbl%0d_src1", k), s1, tbl[k].e1);
            chk($sformatf("tbl%0d_src2", k), s2, tbl[k].e2);
            chk($sformatf("tbl%0d_dbg", k), dd, tbl[k].ed);
            chk($sformatf("tbl%0d_nobyp_src1", k), n1, tbl[k].en);
            commit();
        end
        @(negedge clk);
        we = 1'b0;

        // 5: async reset mid-cycle, write during reset lost, first write after release lands
        do_write(5'd7, 32'hDEAD_BEEF);
        r1 = 5'd7; dbg = 5'd7;
        #1;
        chk("pre_rst_src1", s1, 32'hDEAD_BEEF);
        #1 rst_n = 1'b0;
        #1;
        chk("async_rst_src1", s1, 32'h0);
        chk("async_rst_dbg", dd, 32'h0);
        for (int i = 0; i < 32; i++) mem[i] = '0;
        we = 1'b1; wr = 5'd7; wd = 32'h1234_5678;
        #1;
        chk("rst_nobypass_src1", s1, 32'h0);
        @(posedge clk);
        #1;
        chk("rst_write_lost", dd, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("release_bypass", s1, 32'h1234_5678);
        chk("release_dbg_pre", dd, 32'h0);
        commit();
        #1;
        chk("release_write_lands", dd, 32'h1234_5678);
        @(negedge clk);
        we = 1'b0;

        // 6: random traffic against the reference array
        for (int c = 0; c < 10000; c++) begin
            @(negedge clk);
            we = 1'($urandom_range(0, 1));
            wr = 5'($urandom);
            wd = $urandom;
            r1 = ($urandom_range(0, 3) == 0) ? wr : 5'($urandom);
            r2 = ($urandom_range(0, 3) == 0) ? wr : 5'($urandom);
            dbg = ($urandom_range(0, 3) == 0) ? wr : 5'($urandom);
            #1;
            chk("rnd_src1", s1, ref_rd(r1, 1'b1));
            chk("rnd_src2", s2, ref_rd(r2, 1'b1));
            chk("rnd_dbg", dd, ref_rd(dbg, 1'b0));
            chk("rnd_nobyp_src1", n1, ref_rd(r1, 1'b0));
            chk("rnd_nobyp_src2", n2, ref_rd(r2, 1'b0));
            chk("rnd_nobyp_dbg", nd, ref_rd(dbg, 1'b0));
            commit();
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
